// File: rtl/render_pkg.sv
// Shared types and default parameters for the per-frame render sequencer.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR_START,
        CLR_WAIT,
        UPD,
        SETTLE_W,
        DRW_START,
        DRW_WAIT
    } render_state_t;

    localparam int unsigned COORD_W_DEF  = 11;
    localparam int unsigned COLOR_W_DEF  = 3;
    localparam int unsigned H_RES_DEF    = 640;
    localparam int unsigned V_RES_DEF    = 480;
    localparam int unsigned BG_COLOR_DEF = 0;
    localparam int unsigned SETTLE_DEF   = 2;
    localparam int unsigned TIMEOUT_DEF  = 1 << 20;

    // The two states in which a pass streams pixels and the timeout runs.
    function automatic logic is_wait_state(input render_state_t s);
        return (s == CLR_WAIT) || (s == DRW_WAIT);
    endfunction

endpackage

// File: rtl/pixel_clip_reg.sv
// Selects the active pass's pixel, clips it to the visible area and registers
// it onto the framebuffer write port.
module pixel_clip_reg
    import render_pkg::*;
#(
    parameter int unsigned COORD_W  = COORD_W_DEF,
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned H_RES    = H_RES_DEF,
    parameter int unsigned V_RES    = V_RES_DEF,
    parameter int unsigned BG_COLOR = BG_COLOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_active_i,
    input  logic               drw_active_i,
    input  logic [COORD_W-1:0] clear_x_i,
    input  logic [COORD_W-1:0] clear_y_i,
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] draw_y_i,
    input  logic [COLOR_W-1:0] draw_color_i,
    output logic               pixel_we_o,
    output logic [COORD_W-1:0] pixel_x_o,
    output logic [COORD_W-1:0] pixel_y_o,
    output logic [COLOR_W-1:0] pixel_color_o
);

    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_RES);
    localparam logic [COLOR_W-1:0] BG    = COLOR_W'(BG_COLOR);

    logic               active;
    logic               we_d;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;
    logic [COLOR_W-1:0] color_d;

    logic               we_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COLOR_W-1:0] color_q;

    always_comb begin
        active  = clr_active_i | drw_active_i;
        x_d     = clr_active_i ? clear_x_i : draw_x_i;
        y_d     = clr_active_i ? clear_y_i : draw_y_i;
        color_d = clr_active_i ? BG        : draw_color_i;
        we_d    = active && (x_d < H_LIM) && (y_d < V_LIM);
    end

    // Address/data are captured even for clipped pixels; outside a pass they hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            we_q <= we_d;
            if (active) begin
                x_q     <= x_d;
                y_q     <= y_d;
                color_q <= color_d;
            end
        end
    end

    assign pixel_we_o    = we_q;
    assign pixel_x_o     = x_q;
    assign pixel_y_o     = y_q;
    assign pixel_color_o = color_q;

endmodule

// File: rtl/render_sequencer.sv
// Per-frame controller: erase pass, game-state update, settle delay, draw pass,
// with a single clipped and registered framebuffer write port.
module render_sequencer
    import render_pkg::*;
#(
    parameter int unsigned COORD_W  = COORD_W_DEF,
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned H_RES    = H_RES_DEF,
    parameter int unsigned V_RES    = V_RES_DEF,
    parameter int unsigned BG_COLOR = BG_COLOR_DEF,
    parameter int unsigned SETTLE   = SETTLE_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               clear_done,
    input  logic [COORD_W-1:0] clear_x,
    input  logic [COORD_W-1:0] clear_y,
    input  logic               draw_done,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               clear_enable,
    output logic               draw_enable,
    output logic               update_pulse,
    output logic               pixel_we,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT) + 1;
    localparam int ST_W = $clog2(SETTLE + 1) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE - 1);
    localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);

    render_state_t   state_q;
    logic [TO_W-1:0] wait_cnt_q;
    logic [ST_W-1:0] settle_cnt_q;
    logic            clear_enable_q;
    logic            draw_enable_q;
    logic            update_pulse_q;
    logic            busy_q;
    logic            overrun_q;
    logic            timeout_err_q;

    logic            timeout_hit;
    logic            clr_active;
    logic            drw_active;

    // The cycle that trips the timeout is not a write cycle, so we=0 right after abort.
    assign timeout_hit = is_wait_state(state_q) && (wait_cnt_q == TO_LAST);
    assign clr_active  = (state_q == CLR_WAIT) && !timeout_hit;
    assign drw_active  = (state_q == DRW_WAIT) && !timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            clear_enable_q <= 1'b0;
            draw_enable_q  <= 1'b0;
            update_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            clear_enable_q <= 1'b0;
            draw_enable_q  <= 1'b0;
            update_pulse_q <= 1'b0;

            // Ticks are never queued; one arriving mid-frame is only flagged.
            if (frame_tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q        <= CLR_START;
                        clear_enable_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                CLR_START: begin
                    state_q    <= CLR_WAIT;
                    wait_cnt_q <= '0;
                end
                CLR_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + TO_ONE;
                    if (timeout_hit) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else if (clear_done) begin
                        state_q        <= UPD;
                        update_pulse_q <= 1'b1;
                    end
                end
                UPD: begin
                    state_q      <= SETTLE_W;
                    settle_cnt_q <= '0;
                end
                SETTLE_W: begin
                    settle_cnt_q <= settle_cnt_q + ST_ONE;
                    if (settle_cnt_q == ST_LAST) begin
                        state_q       <= DRW_START;
                        draw_enable_q <= 1'b1;
                    end
                end
                DRW_START: begin
                    state_q    <= DRW_WAIT;
                    wait_cnt_q <= '0;
                end
                DRW_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + TO_ONE;
                    if (timeout_hit) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else if (draw_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    pixel_clip_reg #(
        .COORD_W  (COORD_W),
        .COLOR_W  (COLOR_W),
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .BG_COLOR (BG_COLOR)
    ) u_pixel_clip_reg (
        .clk           (clk),
        .reset         (reset),
        .clr_active_i  (clr_active),
        .drw_active_i  (drw_active),
        .clear_x_i     (clear_x),
        .clear_y_i     (clear_y),
        .draw_x_i      (draw_x),
        .draw_y_i      (draw_y),
        .draw_color_i  (draw_color),
        .pixel_we_o    (pixel_we),
        .pixel_x_o     (pixel_x),
        .pixel_y_o     (pixel_y),
        .pixel_color_o (pixel_color)
    );

    assign clear_enable = clear_enable_q;
    assign draw_enable  = draw_enable_q;
    assign update_pulse = update_pulse_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule
